ni_packet_injector: RTL and testbench

- Network-interface source side of the mesh router's look-ahead routing protocol.
- Accepts one packet at a time from the tile and splits it into flits. Injects the flits into the local router's LOCAL input port under credit-based, per-VC flow control.
- Routers only compute the port for the next hop, so the injector computes the first-hop output port of its own router (plain X-Y). That port goes into the header flit's look-ahead field.

---
 rtl/npu_network_defines_pkg.sv | 35 +++
 rtl/ni_packet_injector_credit_counter.sv | 39 +++
 rtl/ni_packet_injector.sv | 141 ++++++++++++++
 tb/tb_ni_packet_injector.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_network_defines_pkg.sv
// Shared mesh-network definitions: port and flit-type encodings, address/VC widths
// and the header fields that every flit carries.
package npu_network_defines;

  localparam int unsigned TOT_X_NODE_W = 3;
  localparam int unsigned TOT_Y_NODE_W = 3;
  localparam int unsigned VC_W         = 1;
  localparam int unsigned PORT_NUM_W   = 3;

  typedef enum logic [PORT_NUM_W-1:0] {
    LOCAL = 3'd0,
    EAST  = 3'd1,
    NORTH = 3'd2,
    WEST  = 3'd3,
    SOUTH = 3'd4
  } port_t;

  typedef enum logic [1:0] {
    HEADER = 2'd0,
    BODY   = 2'd1,
    TAIL   = 2'd2,
    HT     = 2'd3
  } flit_type_t;

  typedef struct packed {
    flit_type_t              flit_type;
    logic [VC_W-1:0]         vc;
    port_t                   la_port;
    logic [TOT_X_NODE_W-1:0] dest_x;
    logic [TOT_Y_NODE_W-1:0] dest_y;
  } flit_header_t;

  localparam int unsigned FLIT_HDR_W = $bits(flit_header_t);

endpackage

// File: rtl/ni_packet_injector_credit_counter.sv
// Per-VC credit counter for the router's input buffer: reloads to full on reset,
// one credit consumed per sent flit, one returned per credit pulse.
module ni_credit_counter #(
  parameter int unsigned BUFFER_DEPTH = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic avail_o
);

  localparam int unsigned CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_DEPTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A return while already full is a router protocol error; hold at full.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i) begin
      if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= FULL;
    else         cnt_q <= cnt_d;
  end

  assign avail_o = (cnt_q != '0);

  a_no_credit_overflow: assert property (
    @(posedge clk_i) disable iff (reset_i) !(inc_i && !dec_i && (cnt_q == FULL))
  );

endmodule

// File: rtl/ni_packet_injector.sv
// Network-interface source: splits one tile packet into flits and injects them into
// the local router under per-VC credit flow control, with X-Y look-ahead port.
module ni_packet_injector
  import npu_network_defines::*;
#(
  parameter int unsigned MY_X_ADDR    = 0,
  parameter int unsigned MY_Y_ADDR    = 0,
  parameter int unsigned PACKET_W     = 64,
  parameter int unsigned FLIT_DATA_W  = 32,
  parameter int unsigned N_VC         = 2,
  parameter int unsigned BUFFER_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                pkt_valid,
  output logic                                pkt_ready,
  input  logic [PACKET_W-1:0]                 pkt_data,
  input  logic [TOT_X_NODE_W-1:0]             pkt_dest_x,
  input  logic [TOT_Y_NODE_W-1:0]             pkt_dest_y,
  input  logic [VC_W-1:0]                     pkt_vc,
  output logic                                flit_valid,
  output logic [FLIT_HDR_W+FLIT_DATA_W-1:0]   flit_out,
  input  logic [N_VC-1:0]                     credit_in
);

  localparam int unsigned N_FLIT = (PACKET_W + FLIT_DATA_W - 1) / FLIT_DATA_W;
  localparam int unsigned IDX_W  = (N_FLIT > 1) ? $clog2(N_FLIT) : 1;
  localparam int unsigned PAD_W  = N_FLIT * FLIT_DATA_W;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_FLIT - 1);
  localparam logic [TOT_X_NODE_W-1:0] MY_X     = TOT_X_NODE_W'(MY_X_ADDR);
  localparam logic [TOT_Y_NODE_W-1:0] MY_Y     = TOT_Y_NODE_W'(MY_Y_ADDR);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PAD_W-1:0]        data_q, data_d;
  logic [VC_W-1:0]         vc_q, vc_d;
  port_t                   port_q, port_d;
  logic [TOT_X_NODE_W-1:0] dx_q, dx_d;
  logic [TOT_Y_NODE_W-1:0] dy_q, dy_d;

  logic [N_VC-1:0] avail;
  logic [N_VC-1:0] dec;
  logic            accept;
  flit_header_t    hdr;

  function automatic port_t first_hop(input logic [TOT_X_NODE_W-1:0] dx,
                                      input logic [TOT_Y_NODE_W-1:0] dy);
    logic signed [TOT_X_NODE_W:0] xd;
    logic signed [TOT_Y_NODE_W:0] yd;
    port_t p;
    xd = $signed({1'b0, dx}) - $signed({1'b0, MY_X});
    yd = $signed({1'b0, dy}) - $signed({1'b0, MY_Y});
    if (xd[TOT_X_NODE_W])       p = WEST;
    else if (xd != '0)          p = EAST;
    else if (yd[TOT_Y_NODE_W])  p = NORTH;
    else if (yd != '0)          p = SOUTH;
    else                        p = LOCAL;
    return p;
  endfunction

  assign flit_valid = (state_q == SEND) && avail[vc_q];
  assign pkt_ready  = (state_q == IDLE) || (flit_valid && (idx_q == LAST_IDX));
  assign accept     = pkt_valid && pkt_ready;

  for (genvar v = 0; v < N_VC; v++) begin : g_credit
    assign dec[v] = flit_valid && (vc_q == VC_W'(v));
    ni_credit_counter #(
      .BUFFER_DEPTH(BUFFER_DEPTH)
    ) u_credit (
      .clk_i  (clk),
      .reset_i(reset),
      .inc_i  (credit_in[v]),
      .dec_i  (dec[v]),
      .avail_o(avail[v])
    );
  end

  // Payload is kept as a shift register so the current flit is always the low slice;
  // an accept on the last flit's cycle overrides the return to IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    vc_d    = vc_q;
    port_d  = port_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    if (flit_valid) begin
      idx_d  = idx_q + 1'b1;
      data_d = data_q >> FLIT_DATA_W;
      if (idx_q == LAST_IDX) state_d = IDLE;
    end
    if (accept) begin
      state_d = SEND;
      idx_d   = '0;
      data_d  = PAD_W'(pkt_data);
      vc_d    = pkt_vc;
      port_d  = first_hop(pkt_dest_x, pkt_dest_y);
      dx_d    = pkt_dest_x;
      dy_d    = pkt_dest_y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      vc_q    <= '0;
      port_q  <= LOCAL;
      dx_q    <= '0;
      dy_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      vc_q    <= vc_d;
      port_q  <= port_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
    end
  end

  always_comb begin
    hdr         = '0;
    hdr.vc      = vc_q;
    hdr.la_port = port_q;
    hdr.dest_x  = dx_q;
    hdr.dest_y  = dy_q;
    if (N_FLIT == 1)            hdr.flit_type = HT;
    else if (idx_q == '0)       hdr.flit_type = HEADER;
    else if (idx_q == LAST_IDX) hdr.flit_type = TAIL;
    else                        hdr.flit_type = BODY;
  end

  assign flit_out = flit_valid ? {hdr, data_q[FLIT_DATA_W-1:0]} : '0;

endmodule

// File: tb/tb_ni_packet_injector.sv
// Scoreboard bench: stimulus pushes expected flits per accepted packet, a negedge
// monitor compares valid/ready/flit against a credit-accounting reference model.
module tb_ni_packet_injector;
  import npu_network_defines::*;

  localparam int unsigned BD  = 2;
  localparam int unsigned BDB = 4;
  localparam int unsigned FW  = FLIT_HDR_W + 32;
  localparam int          MYX = 1;
  localparam int          MYY = 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  // main DUT: 96-bit packets, 3 flits, 2 credits per VC
  logic                    pkt_valid  = 1'b0;
  logic                    pkt_ready;
  logic [95:0]             pkt_data   = '0;
  logic [TOT_X_NODE_W-1:0] pkt_dest_x = '0;
  logic [TOT_Y_NODE_W-1:0] pkt_dest_y = '0;
  logic [VC_W-1:0]         pkt_vc     = '0;
  logic                    flit_valid;
  logic [FW-1:0]           flit_out;
  logic [1:0]              credit_in  = '0;

  // second DUT: 32-bit packets, single HT flit
  logic                    b_valid  = 1'b0;
  logic                    b_ready;
  logic [31:0]             b_data   = '0;
  logic [TOT_X_NODE_W-1:0] b_dx     = '0;
  logic [TOT_Y_NODE_W-1:0] b_dy     = '0;
  logic [VC_W-1:0]         b_vc     = '0;
  logic                    b_fv;
  logic [FW-1:0]           b_fo;
  logic [1:0]              b_credit = '0;

  ni_packet_injector #(
    .MY_X_ADDR(MYX), .MY_Y_ADDR(MYY), .PACKET_W(96), .FLIT_DATA_W(32),
    .N_VC(2), .BUFFER_DEPTH(BD)
  ) u_dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_data(pkt_data), .pkt_dest_x(pkt_dest_x), .pkt_dest_y(pkt_dest_y),
    .pkt_vc(pkt_vc), .flit_valid(flit_valid), .flit_out(flit_out), .credit_in(credit_in)
  );

  ni_packet_injector #(
    .MY_X_ADDR(MYX), .MY_Y_ADDR(MYY), .PACKET_W(32), .FLIT_DATA_W(32),
    .N_VC(2), .BUFFER_DEPTH(BDB)
  ) u_ht (
    .clk(clk), .reset(reset), .pkt_valid(b_valid), .pkt_ready(b_ready),
    .pkt_data(b_data), .pkt_dest_x(b_dx), .pkt_dest_y(b_dy),
    .pkt_vc(b_vc), .flit_valid(b_fv), .flit_out(b_fo), .credit_in(b_credit)
  );

  initial forever #5 clk = ~clk;

  // reference model state
  logic [FW-1:0] q[$];
  int            qvc[$];
  logic [FW-1:0] qb[$];
  int            cred[2] = '{BD, BD};
  int            occ[2]  = '{0, 0};
  int            credb   = BDB;
  int            mode    = 1;          // router credit return: 0 none, 1 prompt, 2 random
  int            man_req[2]  = '{0, 0};
  int            man_done[2] = '{0, 0};
  logic [1:0]    nxt_credit = '0;
  int            tmo_cnt = 0;
  int            tmo_seen = 0;
  bit            started = 1'b0;
  bit            post_rst = 1'b0;
  bit            exp_v, exp_r, exp_vb, exp_rb, pulse;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [FW-1:0] exp_flit(int k, int n, int vc, int dx, int dy,
                                             logic [95:0] data);
    port_t       p;
    flit_type_t  t;
    logic [95:0] sh;
    logic [0:0]  v1;
    logic [2:0]  x3, y3;
    if (dx - MYX > 0)      p = EAST;
    else if (dx - MYX < 0) p = WEST;
    else if (dy - MYY > 0) p = SOUTH;
    else if (dy - MYY < 0) p = NORTH;
    else                   p = LOCAL;
    if (n == 1)          t = HT;
    else if (k == 0)     t = HEADER;
    else if (k == n - 1) t = TAIL;
    else                 t = BODY;
    sh = data >> (32 * k);
    v1 = 1'(vc);
    x3 = 3'(dx);
    y3 = 3'(dy);
    return {t, v1, p, x3, y3, sh[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (tmo_cnt != tmo_seen) begin
        checks++;
        errors++;
        $display("FAIL timeout waiting on DUT: actual %0d required %0d", tmo_seen, tmo_cnt);
        tmo_seen = tmo_cnt;
      end
      if (started) begin
        if (post_rst) begin
          chk("reset_flit_out", 64'(flit_out), 64'h0);
          chk("reset_flit_out_b", 64'(b_fo), 64'h0);
          post_rst = 1'b0;
        end
        exp_v = 1'b0;
        if (q.size() > 0) exp_v = (cred[qvc[0]] > 0);
        exp_r = (q.size() == 0) || ((q.size() == 1) && exp_v);
        chk("flit_valid", 64'(flit_valid), 64'(exp_v));
        chk("pkt_ready", 64'(pkt_ready), 64'(exp_r));
        if (exp_v && flit_valid) chk("flit_out", 64'(flit_out), 64'(q[0]));
        if (exp_v) begin
          cred[qvc[0]]--;
          occ[qvc[0]]++;
          void'(q.pop_front());
          void'(qvc.pop_front());
        end
        for (int v = 0; v < 2; v++) if (credit_in[v]) cred[v]++;
        if (!reset && pkt_valid && pkt_ready) begin
          for (int k = 0; k < 3; k++) begin
            q.push_back(exp_flit(k, 3, int'(pkt_vc), int'(pkt_dest_x), int'(pkt_dest_y), pkt_data));
            qvc.push_back(int'(pkt_vc));
          end
        end

        exp_vb = (qb.size() > 0) && (credb > 0);
        exp_rb = (qb.size() == 0) || ((qb.size() == 1) && exp_vb);
        chk("ht_flit_valid", 64'(b_fv), 64'(exp_vb));
        chk("ht_pkt_ready", 64'(b_ready), 64'(exp_rb));
        if (exp_vb && b_fv) chk("ht_flit_out", 64'(b_fo), 64'(qb[0]));
        if (exp_vb) begin
          credb--;
          void'(qb.pop_front());
        end
        if (!reset && b_valid && b_ready)
          qb.push_back(exp_flit(0, 1, int'(b_vc), int'(b_dx), int'(b_dy), {64'h0, b_data}));

        // router side: return one freed slot per VC per cycle
        for (int v = 0; v < 2; v++) begin
          pulse = 1'b0;
          if (occ[v] > 0) begin
            if (man_req[v] != man_done[v]) begin
              pulse = 1'b1;
              man_done[v] = man_req[v];
            end else if (mode == 1) pulse = 1'b1;
            else if (mode == 2) pulse = ($urandom_range(0, 2) == 0);
          end
          if (pulse) occ[v]--;
          nxt_credit[v] = pulse;
        end
        if (reset) begin
          q.delete();
          qvc.delete();
          qb.delete();
          cred = '{BD, BD};
          occ = '{0, 0};
          credb = BDB;
          nxt_credit = '0;
          post_rst = 1'b1;
        end
      end
    end
  end

  initial begin : router_drive
    forever begin
      @(posedge clk);
      #1;
      credit_in = nxt_credit;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int dx, input int dy, input int vc, input logic [95:0] d);
    bit acc;
    acc = 1'b0;
    pkt_valid  = 1'b1;
    pkt_dest_x = TOT_X_NODE_W'(dx);
    pkt_dest_y = TOT_Y_NODE_W'(dy);
    pkt_vc     = VC_W'(vc);
    pkt_data   = d;
    for (int i = 0; (i < 300) && !acc; i++) begin
      @(negedge clk);
      acc = pkt_ready;
      @(posedge clk);
      #1;
    end
    pkt_valid = 1'b0;
    if (!acc) tmo_cnt++;
  endtask

  task automatic send_b(input int dx, input int dy, input int vc, input logic [31:0] d);
    bit acc;
    acc = 1'b0;
    b_valid = 1'b1;
    b_dx    = TOT_X_NODE_W'(dx);
    b_dy    = TOT_Y_NODE_W'(dy);
    b_vc    = VC_W'(vc);
    b_data  = d;
    for (int i = 0; (i < 300) && !acc; i++) begin
      @(negedge clk);
      acc = b_ready;
      @(posedge clk);
      #1;
    end
    b_valid = 1'b0;
    if (!acc) tmo_cnt++;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (((q.size() != 0) || (qb.size() != 0)) && (i < 400)) begin
      step(1);
      i++;
    end
    if ((q.size() != 0) || (qb.size() != 0)) tmo_cnt++;
  endtask

  initial begin : stimulus
    int gap;
    repeat (3) @(posedge clk);
    #1;
    started = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);

    // full credits with prompt returns: HEADER/BODY/TAIL back to back, EAST
    mode = 1;
    send(3, 1, 0, 96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF);
    drain();
    step(4);

    // no returns: vc1 stalls after two flits, one pulse releases the TAIL
    mode = 0;
    send(2, 3, 1, {$urandom, $urandom, $urandom});
    step(5);
    man_req[1]++;
    drain();
    // vc0 still holds its full two credits
    send(0, 0, 0, {$urandom, $urandom, $urandom});
    step(4);
    mode = 1;
    drain();
    step(4);

    // two packets held valid back to back
    send(1, 2, 0, {$urandom, $urandom, $urandom});
    send(4, 1, 1, {$urandom, $urandom, $urandom});
    drain();
    step(4);

    // reset during the BODY cycle: no TAIL, fresh packet starts with HEADER
    send(3, 3, 1, {$urandom, $urandom, $urandom});
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);
    send(0, 1, 1, {$urandom, $urandom, $urandom});
    drain();
    step(4);

    // randomized traffic with random credit returns
    mode = 2;
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 2);
      step(gap);
      send($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
           {$urandom, $urandom, $urandom});
    end
    drain();
    mode = 1;
    step(6);

    // single-flit packets: WEST, NORTH, SOUTH, LOCAL, all HT
    send_b(0, 2, 0, $urandom);
    send_b(1, 0, 1, $urandom);
    send_b(1, 3, 0, $urandom);
    send_b(1, 1, 1, $urandom);
    drain();
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
